// File: rtl/noc_pkg.sv
// Shared NoC types and helpers for the router input stage.
package noc_pkg;

  localparam int FLIT_W_DEF = 64;

  typedef logic [FLIT_W_DEF-1:0] flit_t;

  // Width of a VC index; a single-VC build still needs a 1-bit field.
  function automatic int vc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Pointer, occupancy and flag control for one virtual-channel FIFO.
module vc_fifo_ctrl #(
  parameter  int DEPTH        = 16,
  parameter  int ON_OFF_DELAY = 2,
  localparam int PTR_W        = $clog2(DEPTH),
  localparam int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  output logic             wr_en_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             buffer_on_o,
  output logic             ovf_o,
  output logic             unf_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, bon_q, bon_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop on a full VC frees the slot the same-cycle push lands in.
  assign do_pop  = pop_i & ~empty_q;
  assign do_push = push_i & (~full_q | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    bon_d    = bon_q;
    if (count_d >= CNT_W'(DEPTH - ON_OFF_DELAY))
      bon_d = 1'b0;
    else if (count_d <= CNT_W'(ON_OFF_DELAY))
      bon_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      bon_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
      bon_q    <= bon_d;
    end
  end

  assign wr_en_o     = do_push;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign buffer_on_o = bon_q;
  // Full implies non-empty, so a same-VC pop always rescues the push.
  assign ovf_o       = push_i & full_q & ~pop_i;
  assign unf_o       = pop_i & empty_q;

endmodule

// File: rtl/vc_input_buffer.sv
// Router input buffer: NUM_VC independent first-word-fall-through FIFOs
// sharing one flat storage array, with on/off flow control per VC.
module vc_input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W       = FLIT_W_DEF,
  parameter int DEPTH        = 16,
  parameter int NUM_VC       = 4,
  parameter int ON_OFF_DELAY = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FLIT_W-1:0]                  flit_in,
  input  logic                               push,
  input  logic [vc_idx_w(NUM_VC)-1:0]        vc_in,
  input  logic                               pop,
  input  logic [vc_idx_w(NUM_VC)-1:0]        vc_sel,
  output logic [FLIT_W-1:0]                  flit_o,
  output logic [NUM_VC-1:0]                  full,
  output logic [NUM_VC-1:0]                  empty,
  output logic [NUM_VC-1:0]                  buffer_on,
  output logic [NUM_VC*$clog2(DEPTH+1)-1:0]  count,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int VC_W    = vc_idx_w(NUM_VC);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRIES = NUM_VC * DEPTH;
  localparam int ADDR_W  = $clog2(ENTRIES);

  logic [NUM_VC-1:0][PTR_W-1:0] wr_ptr, rd_ptr;
  logic [NUM_VC-1:0]            wr_en, ovf_ev, unf_ev;
  logic [ADDR_W-1:0]            wr_addr, rd_addr;
  logic                         overflow_q, underflow_q;
  logic [FLIT_W-1:0]            mem_q [ENTRIES];

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo_ctrl #(
      .DEPTH        (DEPTH),
      .ON_OFF_DELAY (ON_OFF_DELAY)
    ) u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push & (vc_in  == VC_W'(v))),
      .pop_i       (pop  & (vc_sel == VC_W'(v))),
      .wr_en_o     (wr_en[v]),
      .wr_ptr_o    (wr_ptr[v]),
      .rd_ptr_o    (rd_ptr[v]),
      .count_o     (count[v*CNT_W +: CNT_W]),
      .full_o      (full[v]),
      .empty_o     (empty[v]),
      .buffer_on_o (buffer_on[v]),
      .ovf_o       (ovf_ev[v]),
      .unf_o       (unf_ev[v])
    );
  end

  // Linear form of {vc, ptr}; DEPTH need not be a power of two.
  assign wr_addr = ADDR_W'(vc_in)  * ADDR_W'(DEPTH) + ADDR_W'(wr_ptr[vc_in]);
  assign rd_addr = ADDR_W'(vc_sel) * ADDR_W'(DEPTH) + ADDR_W'(rd_ptr[vc_sel]);

  // Storage is deliberately not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (|wr_en) mem_q[wr_addr] <= flit_in;
  end

  assign flit_o = mem_q[rd_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (|ovf_ev);
      underflow_q <= underflow_q | (|unf_ev);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_vc_input_buffer;

  localparam int FW    = 64;
  localparam int DEPTH = 16;
  localparam int NVC   = 4;
  localparam int OOD   = 2;
  localparam int CW    = 5;

  logic            clk, rst;
  logic [FW-1:0]   flit_in, flit_o;
  logic            push, pop;
  logic [1:0]      vc_in, vc_sel;
  logic [NVC-1:0]  full, empty, buffer_on;
  logic [NVC*CW-1:0] count;
  logic            overflow, underflow;

  vc_input_buffer #(.FLIT_W(FW), .DEPTH(DEPTH), .NUM_VC(NVC), .ON_OFF_DELAY(OOD)) dut (
    .clk(clk), .rst(rst), .flit_in(flit_in), .push(push), .vc_in(vc_in),
    .pop(pop), .vc_sel(vc_sel), .flit_o(flit_o), .full(full), .empty(empty),
    .buffer_on(buffer_on), .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [FW-1:0] mq [NVC][$];
  bit            mbon [NVC];
  bit            movf, munf;

  typedef struct {
    bit            p;
    int            vi;
    bit            o;
    int            vs;
    logic [FW-1:0] f;
    bit            chk_f;
    logic [FW-1:0] ef;
    logic [19:0]   ecnt;
    logic [3:0]    eemp;
    bit            eunf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NVC; v++) begin
      mq[v].delete();
      mbon[v] = 1'b1;
    end
    movf = 1'b0;
    munf = 1'b0;
  endtask

  task automatic cmp_model();
    logic [19:0] ec;
    logic [3:0]  ef, ee, eb;
    for (int v = 0; v < NVC; v++) begin
      ec[v*CW +: CW] = CW'(mq[v].size());
      ef[v] = (mq[v].size() == DEPTH);
      ee[v] = (mq[v].size() == 0);
      eb[v] = mbon[v];
    end
    chk("count", 64'(count), 64'(ec));
    chk("full", 64'(full), 64'(ef));
    chk("empty", 64'(empty), 64'(ee));
    chk("buffer_on", 64'(buffer_on), 64'(eb));
    chk("overflow", 64'(overflow), 64'(movf));
    chk("underflow", 64'(underflow), 64'(munf));
  endtask

  task automatic check_reset_state();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'hF);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_bon", 64'(buffer_on), 64'hF);
    chk("rst_flags", 64'({overflow, underflow}), 64'd0);
  endtask

  // One cycle: drive at negedge, check head pre-edge, update model, check post-edge.
  task automatic step(input bit p, input int vi, input bit o, input int vs,
                      input logic [FW-1:0] f, input bit chk_f, input logic [FW-1:0] ef);
    bit pop_ok, push_ok;
    int sz;
    @(negedge clk);
    push = p; vc_in = vi[1:0]; pop = o; vc_sel = vs[1:0]; flit_in = f;
    #1;
    if (mq[vs].size() > 0) chk("flit_o", flit_o, mq[vs][0]);
    if (chk_f) chk("tbl_flit_o", flit_o, ef);
    pop_ok  = o && (mq[vs].size() > 0);
    push_ok = p && ((mq[vi].size() < DEPTH) || (pop_ok && vs == vi));
    if (o && !pop_ok) munf = 1'b1;
    if (p && !push_ok) movf = 1'b1;
    if (pop_ok) void'(mq[vs].pop_front());
    if (push_ok) mq[vi].push_back(f);
    for (int v = 0; v < NVC; v++) begin
      sz = mq[v].size();
      if (sz >= DEPTH - OOD) mbon[v] = 1'b0;
      else if (sz <= OOD) mbon[v] = 1'b1;
    end
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; push = 0; pop = 0;
    model_reset();
    @(negedge clk);
    check_reset_state();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; push = 0; pop = 0; vc_in = 0; vc_sel = 0; flit_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state();
    rst = 1'b1;

    tbl[0] = '{1, 0, 0, 0, 64'hA1, 0, 64'h0,  {5'd0, 5'd0, 5'd0, 5'd1}, 4'b1110, 0};
    tbl[1] = '{1, 3, 0, 0, 64'hB1, 1, 64'hA1, {5'd1, 5'd0, 5'd0, 5'd1}, 4'b0110, 0};
    tbl[2] = '{1, 3, 1, 0, 64'hB2, 1, 64'hA1, {5'd2, 5'd0, 5'd0, 5'd0}, 4'b0111, 0};
    tbl[3] = '{1, 2, 1, 3, 64'hC1, 1, 64'hB1, {5'd1, 5'd1, 5'd0, 5'd0}, 4'b0011, 0};
    tbl[4] = '{0, 0, 1, 3, 64'h0,  1, 64'hB2, {5'd0, 5'd1, 5'd0, 5'd0}, 4'b1011, 0};
    tbl[5] = '{1, 0, 1, 0, 64'hD1, 0, 64'h0,  {5'd0, 5'd1, 5'd0, 5'd1}, 4'b1010, 1};
    tbl[6] = '{0, 0, 1, 0, 64'h0,  1, 64'hD1, {5'd0, 5'd1, 5'd0, 5'd0}, 4'b1011, 1};
    tbl[7] = '{0, 0, 1, 2, 64'h0,  1, 64'hC1, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b1111, 1};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].p, tbl[i].vi, tbl[i].o, tbl[i].vs, tbl[i].f, tbl[i].chk_f, tbl[i].ef);
      chk("tbl_count", 64'(count), 64'(tbl[i].ecnt));
      chk("tbl_empty", 64'(empty), 64'(tbl[i].eemp));
      chk("tbl_underflow", 64'(underflow), 64'(tbl[i].eunf));
    end

    // Hysteresis on VC1: off at 14, stays off until count falls to 2.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(1, 1, 0, 1, 64'h1000 + 64'(i), 0, '0);
      if (i == 12) chk("bon_13", 64'(buffer_on[1]), 64'd1);
    end
    chk("bon_off_14", 64'(buffer_on[1]), 64'd0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 1, '0, 1, 64'h1000 + 64'(i));
      if (i == 10) chk("bon_held_3", 64'(buffer_on[1]), 64'd0);
    end
    chk("bon_on_2", 64'(buffer_on[1]), 64'd1);
    chk("other_vcs", 64'({count[19:10], count[4:0]}), 64'd0);

    // Fill VC2, overflow, then drain in order through the wrap.
    do_reset();
    step(1, 2, 0, 2, 64'hEE, 0, '0);
    step(0, 2, 1, 2, '0, 1, 64'hEE);
    for (int i = 0; i < 16; i++) step(1, 2, 0, 2, 64'h2000 + 64'(i), 0, '0);
    chk("full2", 64'(full[2]), 64'd1);
    chk("cnt2_16", 64'(count[14:10]), 64'd16);
    step(1, 2, 0, 2, 64'hDEAD, 0, '0);
    chk("ovf", 64'(overflow), 64'd1);
    chk("cnt2_drop", 64'(count[14:10]), 64'd16);
    step(1, 2, 1, 2, 64'h2010, 1, 64'h2000);
    chk("full_pp", 64'(full[2]), 64'd1);
    for (int i = 1; i < 17; i++) step(0, 2, 1, 2, '0, 1, 64'h2000 + 64'(i));
    chk("empty2", 64'(empty[2]), 64'd1);

    // VC1 held at 5 under simultaneous push+pop for 20 cycles.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 64'h3000 + 64'(i), 0, '0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 64'h3005 + 64'(i), 1, 64'h3000 + 64'(i));
    chk("cnt1_steady", 64'(count[9:5]), 64'd5);

    // Asynchronous reset between edges, then power-up-like behaviour.
    for (int i = 0; i < 3; i++) step(1, 3, 0, 3, 64'h4000 + 64'(i), 0, '0);
    #2 rst = 1'b0;
    #1 check_reset_state();
    model_reset();
    @(negedge clk);
    push = 0; pop = 0;
    rst = 1'b1;
    step(1, 3, 0, 3, 64'h5A5A, 0, '0);
    step(0, 3, 1, 3, '0, 1, 64'h5A5A);

    // Random traffic: fill-biased phase then drain-biased phase.
    for (int i = 0; i < 3000; i++) begin
      bit p, o;
      p = ($urandom_range(0, 99) < ((i < 1500) ? 75 : 35));
      o = ($urandom_range(0, 99) < ((i < 1500) ? 35 : 75));
      step(p, int'($urandom_range(0, NVC-1)), o, int'($urandom_range(0, NVC-1)),
           {$urandom, $urandom}, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 SHALL have parameter FLIT_W, default 64, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, flits per VC; legal range >= 4, any integer (not restricted to powers of two).
REQ-003 SHALL have parameter NUM_VC, default 4, number of virtual channels; legal range >= 2.
REQ-004 SHALL have parameter ON_OFF_DELAY, default 2, on/off hysteresis margin in flits; legal range 1 .. DEPTH/2 - 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 flit_in  input  FLIT_W  incoming flit.
REQ-008 push  input  1  write flit_in into the VC selected by vc_in.
REQ-009 vc_in  input  clog2(NUM_VC)  target VC for push.
REQ-010 pop  input  1  remove the head flit of the VC selected by vc_sel.
REQ-011 vc_sel  input  clog2(NUM_VC)  VC for read and pop.
REQ-012 flit_o  output  FLIT_W  head flit of VC vc_sel.
REQ-013 full  output  NUM_VC  per-VC full flag.
REQ-014 empty  output  NUM_VC  per-VC empty flag.
REQ-015 buffer_on  output  NUM_VC  per-VC on/off credit to the upstream router (1 = may send).
REQ-016 count  output  NUM_VC*clog2(DEPTH+1)  per-VC occupancy, VC0 in the LSBs.
REQ-017 overflow  output  1  sticky flag: a push was made to a full VC.
REQ-018 underflow  output  1  sticky flag: a pop was made from an empty VC.

Function
REQ-019 Each VC SHALL be an independent circular FIFO with its own read pointer, write pointer and counter. Each pointer wraps from DEPTH-1 to 0.
REQ-020 flit_o SHALL show the head of VC vc_sel combinationally (first-word fall-through, zero-cycle read latency). It is undefined when that VC is empty.
REQ-021 A push to a non-full VC SHALL store the flit at the rising edge; count +1, empty cleared, full set if count_next == DEPTH.
REQ-022 A pop from a non-empty VC SHALL advance the read pointer at the edge; count -1, full cleared, empty set if count_next == 0.
REQ-023 Push and pop to different VCs in the same cycle SHALL both take effect independently.
REQ-024 Push and pop to the same non-empty VC in the same cycle SHALL both take effect: count unchanged, FIFO order preserved. This includes a full VC, which stays full and accepts the flit.
REQ-025 Push and pop to the same empty VC in the same cycle: the push SHALL be accepted, the pop ignored (no bypass), and underflow set.
REQ-026 A push to a full VC (without a same-VC pop) SHALL be dropped with no state change to that VC, and overflow set.
REQ-027 A pop from an empty VC SHALL be ignored, and underflow set.
REQ-028 overflow and underflow SHALL remain set until reset.
REQ-029 buffer_on[v] SHALL be registered and updated as follows:
- cleared when count_next[v] >= DEPTH - ON_OFF_DELAY;
- set when count_next[v] <= ON_OFF_DELAY;
- otherwise held.
REQ-030 full, empty, count and buffer_on SHALL all be registered outputs that reflect post-edge state.

Reset
REQ-031 While rst == 0, asynchronously and for every VC:
- pointers = 0, count = 0;
- empty = 1, full = 0, buffer_on = 1;
- overflow = 0, underflow = 0.
REQ-032 Flit storage SHALL NOT be reset.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered flits. The first push after reset release SHALL land at pointer 0.

Structure
REQ-034 Package noc_pkg SHALL hold the FLIT_W default, flit_t, and the VC index type width function. vc_input_buffer SHALL import it.
REQ-035 Per-VC pointer/counter/flag logic SHALL be the sub-module vc_fifo_ctrl. It is instantiated NUM_VC times via generate, each instance receiving push/pop qualified by its VC match.
REQ-036 Storage SHALL be a single array of NUM_VC*DEPTH entries, addressed as {vc, ptr}.

Verification (DEPTH=16, NUM_VC=4, ON_OFF_DELAY=2)
REQ-037 Push 14 flits to VC1 -> buffer_on[1]=0 after the 14th edge; pop 12 -> buffer_on[1]=1 after the 12th pop (count=2); other VCs untouched.
REQ-038 Push 16 flits to VC2 -> full[2]=1, count=16. A 17th push -> dropped, overflow=1. Then pop 16 -> data returned in order, wrapping correctly; empty[2]=1.
REQ-039 Same cycle push VC0 / pop VC3 (VC3 holding 3 flits) -> count[0]=1, count[3]=2, both flags correct.
REQ-040 VC1 at count 5, simultaneous push+pop VC1 for 20 cycles -> count stays 5, pointers wrap, output order matches input order.
REQ-041 Pop empty VC0 together with push VC0 -> count[0]=1, underflow=1, flit readable next cycle.
REQ-042 Assert rst mid-burst (between edges) -> outputs reach reset values immediately, with no clock edge needed; the subsequent push/pop sequence behaves as from power-up.
